// File: rtl/pllvr_lock_supervisor.sv
// PLLVR supervisor: drives PLL reset and divider selects, qualifies LOCK,
// retries failed lock attempts, and releases downstream resets in a
// staggered order once the PLL is stable. Runtime divider changes are
// taken over a valid/ready handshake while running or failed.
//
// state      | meaning
// -----------+--------------------------------------------------------
// RST_PLL    | pll_reset held high for RESET_HOLD cycles
// WAIT_LOCK  | waiting for LOCK_STABLE consecutive lock cycles or timeout
// RELEASE    | staggered deassertion of rst_out
// RUN        | locked, accepting reconfiguration requests
// FAIL       | retries exhausted, PLL held in reset until reconfigured
module pllvr_lock_supervisor #(
  parameter int unsigned RESET_HOLD   = 12,
  parameter int unsigned LOCK_STABLE  = 1200,
  parameter int unsigned LOCK_TIMEOUT = 12000,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned NUM_RST      = 2,
  parameter int unsigned RST_STAGGER  = 16,
  parameter logic [5:0]  DEF_IDSEL    = 6'd63,
  parameter logic [5:0]  DEF_FBDSEL   = 6'd24,
  parameter logic [5:0]  DEF_ODSEL    = 6'd62
) (
  input  logic                               clkin,
  input  logic                               reset,
  input  logic                               pll_lock,
  output logic                               pll_reset,
  output logic [5:0]                         idsel,
  output logic [5:0]                         fbdsel,
  output logic [5:0]                         odsel,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [5:0]                         cfg_idsel,
  input  logic [5:0]                         cfg_fbdsel,
  input  logic [5:0]                         cfg_odsel,
  output logic [NUM_RST-1:0]                 rst_out,
  output logic                               locked,
  output logic                               lock_lost,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int unsigned HW  = $clog2(RESET_HOLD + 1);
  localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RW  = $clog2((NUM_RST - 1) * RST_STAGGER + 2);
  localparam int unsigned RCW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] REL_LAST = RW'((NUM_RST - 1) * RST_STAGGER);

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          lsync;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] stab_nxt;
  logic          stab_done;
  logic [RW-1:0] rel_cnt;
  logic          accept;

  assign lsync  = sync[1];
  assign accept = cfg_valid && cfg_ready;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clkin) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], pll_lock};
  end

  // Stability count as it will be after this edge; reaching the target wins over timeout.
  always_comb begin
    stab_nxt  = lsync ? stab_cnt + 1'b1 : '0;
    stab_done = (stab_nxt == SW'(LOCK_STABLE));
  end

  // Sequencer: PLL reset, lock qualification, retries, staged release, reconfiguration.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= ST_RST_PLL;
      hold_cnt  <= HW'(RESET_HOLD - 1);
      tmo_cnt   <= '0;
      stab_cnt  <= '0;
      rel_cnt   <= '0;
      pll_reset <= 1'b1;
      rst_out   <= '1;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      cfg_ready <= 1'b0;
      retry_cnt <= '0;
      idsel     <= DEF_IDSEL;
      fbdsel    <= DEF_FBDSEL;
      odsel     <= DEF_ODSEL;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        ST_RST_PLL: begin
          if (hold_cnt == '0) begin
            state     <= ST_WAIT_LOCK;
            pll_reset <= 1'b0;
            tmo_cnt   <= TW'(LOCK_TIMEOUT - 1);
            stab_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          stab_cnt <= stab_nxt;
          if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
          if (stab_done) begin
            state   <= ST_RELEASE;
            rel_cnt <= '0;
          end else if (tmo_cnt == '0) begin
            pll_reset <= 1'b1;
            if (retry_cnt < RCW'(MAX_RETRIES)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_RST_PLL;
              hold_cnt  <= HW'(RESET_HOLD - 1);
            end else begin
              state     <= ST_FAIL;
              fail      <= 1'b1;
              cfg_ready <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (!lsync) begin
            state     <= ST_RST_PLL;
            hold_cnt  <= HW'(RESET_HOLD - 1);
            pll_reset <= 1'b1;
            lock_lost <= 1'b1;
            locked    <= 1'b0;
            rst_out   <= '1;
          end else begin
            for (int i = 0; i < int'(NUM_RST); i++) begin
              if (rel_cnt == RW'(i * RST_STAGGER)) rst_out[i] <= 1'b0;
            end
            if (rel_cnt == REL_LAST) begin
              state     <= ST_RUN;
              locked    <= 1'b1;
              cfg_ready <= 1'b1;
            end
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        ST_RUN, ST_FAIL: begin
          if (accept) begin
            idsel     <= cfg_idsel;
            fbdsel    <= cfg_fbdsel;
            odsel     <= cfg_odsel;
            state     <= ST_RST_PLL;
            hold_cnt  <= HW'(RESET_HOLD - 1);
            pll_reset <= 1'b1;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
            rst_out   <= '1;
            fail      <= 1'b0;
            retry_cnt <= '0;
          end else if (state == ST_RUN && !lsync) begin
            state     <= ST_RST_PLL;
            hold_cnt  <= HW'(RESET_HOLD - 1);
            pll_reset <= 1'b1;
            lock_lost <= 1'b1;
            locked    <= 1'b0;
            rst_out   <= '1;
            cfg_ready <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RST_PLL;
          hold_cnt  <= HW'(RESET_HOLD - 1);
          pll_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pllvr_lock_supervisor.sv
// Bench for pllvr_lock_supervisor: expected output-change events (cycle and
// full output vector) are queued as stimulus is applied and matched in order
// as the outputs actually change.
module tb_pllvr_lock_supervisor;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic [1:0] rst_out;
  logic       locked, lock_lost, fail;
  logic [1:0] retry_cnt;

  pllvr_lock_supervisor #(
    .RESET_HOLD(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(40),
    .MAX_RETRIES(2), .NUM_RST(2), .RST_STAGGER(3)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .rst_out(rst_out), .locked(locked), .lock_lost(lock_lost), .fail(fail),
    .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int          cyc;
    logic [31:0] vec;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] prev;
  logic [5:0]  e_id, e_fb, e_od;
  logic [1:0]  e_rc;

  function automatic logic [31:0] mk(logic pr, logic [1:0] ro, logic lk, logic ll,
                                     logic fl, logic rdy, logic [1:0] rc,
                                     logic [5:0] id, logic [5:0] fb, logic [5:0] od);
    return {5'd0, pr, ro, lk, ll, fl, rdy, rc, id, fb, od};
  endfunction

  function automatic logic [31:0] cur();
    return mk(pll_reset, rst_out, locked, lock_lost, fail, cfg_ready, retry_cnt,
              idsel, fbdsel, odsel);
  endfunction

  localparam logic [31:0] RST_V = {5'd0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                                   6'd63, 6'd24, 6'd62};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // Restart edge s with lsync high throughout: pll_reset low s+4, RELEASE s+12,
  // rst_out[0] low s+13, rst_out[1] low plus locked/ready at s+16.
  task automatic push_lock_seq(input int s);
    push(s + 4,  mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(s + 13, mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(s + 16, mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, e_rc, e_id, e_fb, e_od));
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clkin);
  endtask

  task automatic set_sel(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
    e_id = id; e_fb = fb; e_od = od;
    cfg_idsel = id; cfg_fbdsel = fb; cfg_odsel = od;
  endtask

  always @(posedge clkin) cyc <= cyc + 1;

  // Event monitor: every change of the output vector must match the queue head.
  always @(negedge clkin) begin
    logic [31:0] v;
    ev_t e;
    if (mon_en) begin
      v = cur();
      if (v !== prev) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_event", v, prev);
        end else begin
          e = exp_q.pop_front();
          check_val("event_cycle", cyc, e.cyc);
          check_val("event_value", v, e.vec);
        end
        prev = v;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r, s;
    reset = 1'b1; pll_lock = 1'b0; cfg_valid = 1'b0;
    cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
    e_id = 6'd63; e_fb = 6'd24; e_od = 6'd62; e_rc = 2'd0;
    repeat (3) @(negedge clkin);
    check_val("reset_state", cur(), RST_V);
    prev = RST_V;
    mon_en = 1'b1;

    // Attempt 1 times out, attempt 2 reaches stability exactly at its timeout edge.
    r = cyc;
    push(r + 4,  mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, e_id, e_fb, e_od));
    push(r + 44, mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, e_id, e_fb, e_od));
    e_rc = 2'd1;
    push(r + 48, mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(r + 89, mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(r + 92, mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, e_rc, e_id, e_fb, e_od));
    reset = 1'b0;
    wait_until(r + 78);
    pll_lock = 1'b1;
    wait_until(r + 100);
    check_val("pending_after_first_lock", exp_q.size(), 0);

    // Lock loss in RUN, then relock with a one-cycle glitch in WAIT_LOCK.
    c = cyc;
    push(c + 3,  mk(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(c + 4,  mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(c + 7,  mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(c + 22, mk(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(c + 25, mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, e_rc, e_id, e_fb, e_od));
    for (int k = 0; k <= 30; k++) begin
      pll_lock = (k <= 4 || k == 10) ? 1'b0 : 1'b1;
      @(negedge clkin);
    end
    check_val("pending_after_relock", exp_q.size(), 0);

    // Reconfigure from RUN; a request while not ready is ignored.
    c = cyc;
    set_sel(6'd1, 6'd20, 6'd2);
    e_rc = 2'd0;
    cfg_valid = 1'b1;
    push(c + 1, mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push_lock_seq(c + 1);
    @(negedge clkin);
    cfg_valid = 1'b0;
    s = c + 1;
    wait_until(s + 6);
    cfg_idsel = 6'd40; cfg_fbdsel = 6'd33; cfg_odsel = 6'd41;
    cfg_valid = 1'b1;
    wait_until(s + 9);
    cfg_valid = 1'b0;
    wait_until(c + 30);
    check_val("pending_after_cfg_run", exp_q.size(), 0);

    // Reset from RUN with lock absent: three attempts, then FAIL.
    c = cyc;
    set_sel(6'd63, 6'd24, 6'd62);
    e_rc = 2'd0;
    r = c + 1;
    push(r, RST_V);
    pll_lock = 1'b0;
    reset = 1'b1;
    @(negedge clkin);
    check_val("reset_from_run", cur(), RST_V);
    reset = 1'b0;
    push(r + 4,   mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, e_id, e_fb, e_od));
    push(r + 44,  mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, e_id, e_fb, e_od));
    push(r + 48,  mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, e_id, e_fb, e_od));
    push(r + 88,  mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, e_id, e_fb, e_od));
    push(r + 92,  mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, e_id, e_fb, e_od));
    push(r + 132, mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, e_id, e_fb, e_od));
    wait_until(r + 160);
    check_val("pending_after_fail", exp_q.size(), 0);

    // Reconfigure from FAIL clears fail and retry count, then locks.
    c = cyc;
    set_sel(6'd7, 6'd20, 6'd9);
    e_rc = 2'd0;
    cfg_valid = 1'b1;
    pll_lock = 1'b1;
    push(c + 1, mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push_lock_seq(c + 1);
    @(negedge clkin);
    cfg_valid = 1'b0;
    wait_until(c + 30);
    check_val("pending_after_cfg_fail", exp_q.size(), 0);

    // Accept and lock loss on the same edge: accept wins, no lock_lost pulse.
    c = cyc;
    pll_lock = 1'b0;
    wait_until(c + 2);
    set_sel(6'd21, 6'd22, 6'd23);
    cfg_valid = 1'b1;
    push(c + 3, mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push_lock_seq(c + 3);
    wait_until(c + 3);
    cfg_valid = 1'b0;
    pll_lock = 1'b1;
    wait_until(c + 30);
    check_val("pending_after_accept_vs_loss", exp_q.size(), 0);

    // Reset in WAIT_LOCK after a divider change restores default selects.
    c = cyc;
    set_sel(6'd11, 6'd12, 6'd13);
    cfg_valid = 1'b1;
    push(c + 1, mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    push(c + 5, mk(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, e_rc, e_id, e_fb, e_od));
    @(negedge clkin);
    cfg_valid = 1'b0;
    wait_until(c + 7);
    r = c + 8;
    push(r, RST_V);
    reset = 1'b1;
    @(negedge clkin);
    check_val("reset_in_wait_lock", cur(), RST_V);
    reset = 1'b0;
    set_sel(6'd63, 6'd24, 6'd62);
    push_lock_seq(r);
    wait_until(r + 30);
    check_val("pending_after_reset_wait", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
